cm0_wic_seq: RTL
================

# cm0_wic_seq

Wake-up interrupt controller sequencer for the always-on domain of the Cortex-M0 subsystem. It runs the WIC deep-sleep request/acknowledge handshake with the NVIC and holds the WIC mask loaded by the NVIC. During deep sleep it latches masked interrupt, NMI and RXEV events, then raises a wake-up request so the power controller can restore the core. It sits between the NVIC (`wic_*` handshake and mask signals) and the system power controller.

## Interface
- `WICLINES`, 34: wake-up lines. Bit 0 is RXEV, bit 1 is NMI, bits `[WICLINES-1:2]` are IRQ0 upward. Legal range 3..34.
- `sclk`  in  1  free-running system clock; the only clock.
- `hreset_n`  in  1  asynchronous active-low reset.
- `wic_en_i`  in  1  system enable for WIC-mode deep sleep.
- `wic_ds_ack_n_i`  in  1  NVIC acknowledge, active-low, synchronous to `sclk`.
- `wic_load_i`  in  1  one-cycle strobe; capture `wic_mask_i`.
- `wic_clear_i`  in  1  one-cycle strobe; clear mask and pend.
- `wic_mask_i`  in  WICLINES  mask presented by the NVIC.
- `sleeping_i`  in  1  core sleeping.
- `sleep_deep_i`  in  1  core in deep sleep.
- `int_i`  in  WICLINES  raw wake-up lines, already synchronous, level.
- `wic_ds_req_n_o`  out  1  WIC request to the NVIC, active-low.
- `wic_mask_o`  out  WICLINES  currently held mask.
- `wic_pend_o`  out  WICLINES  latched pending events, for replay to the NVIC.
- `wakeup_o`  out  1  wake request to the power controller.
- `wic_active_o`  out  1  WIC handshake complete; WIC owns wake-up detection.

## Operation
- FSM states: IDLE, REQ, ARMED, SLEEP, DROP, with a forced-wake flag `frc`.
- IDLE:
  - `wic_en_i`=1 → REQ.
- REQ (`wic_ds_req_n_o`=0):
  - ack_n=0 → ARMED.
  - `wic_en_i`=0 → DROP.
- ARMED (req=0, `wic_active_o`=1):
  - `wic_en_i`=0 → DROP.
  - ack_n=1 (protocol loss) → REQ, and `mask_vld` is cleared.
  - `sleeping_i & sleep_deep_i & mask_vld` → SLEEP.
- SLEEP:
  - Each cycle, `pend |= int_i & mask`.
  - ack_n=1 sets `frc`.
  - `sleeping_i`=0 → ARMED, or → REQ if `frc`; `frc` is cleared on exit.
  - `wic_en_i`=0 is ignored until exit.
- DROP (req_n=1):
  - ack_n=1 → IDLE. `mask_vld` and the mask are cleared on entry to IDLE.
- Mask register:
  - `wic_load_i` → mask ← `wic_mask_i`, `mask_vld` ← 1.
  - `wic_clear_i` → mask ← 0, `mask_vld` ← 0.
  - Clear beats load when both are asserted in the same cycle.
  - Load/clear are honoured only in ARMED or SLEEP; they are ignored elsewhere.
- Pend register:
  - `wic_clear_i` zeroes pend.
  - A set in the same cycle as a clear wins for that bit, so no event is lost.
  - Pend holds across the SLEEP→ARMED exit until it is cleared.
- `wakeup_o` = registered (`|pend` | `frc`), gated to SLEEP.

## Timing
- Reset values:
  - state = IDLE.
  - `wic_ds_req_n_o`=1.
  - `wic_mask_o`=0, `wic_pend_o`=0.
  - `wakeup_o`=0, `wic_active_o`=0.
  - `mask_vld`=0, `frc`=0.
- All outputs are registered.
- `wic_ds_req_n_o` falls 1 cycle after `wic_en_i` is sampled high in IDLE.
- `wic_active_o` rises 1 cycle after ack_n is sampled low in REQ.
- An `int_i` edge in SLEEP with its mask bit set:
  - `wic_pend_o` bit set at +1 cycle.
  - `wakeup_o` high at +2 cycles.
- `wakeup_o` stays high until `sleeping_i` is sampled low. It falls in the same cycle the FSM leaves SLEEP.
- Reset asserted mid-handshake: all state returns to reset values immediately (asynchronous). The NVIC sees req_n=1 and must release ack.

## Structure
- Package `cm0_wic_pkg` holds:
  - State encoding: one-hot, 5 bits.
  - Line index constants: `WIC_RXEV=0`, `WIC_NMI=1`, `WIC_IRQ0=2`.
- Sub-module `cm0_wic_pend` holds the mask/pend register pair, the clear-vs-set priority and the OR-reduce, parameterised by `WICLINES`.
- The FSM stays in the top module.

## Test plan
- Reset, then `wic_en_i`=1 → req_n low at +1. Ack_n low → `wic_active_o`=1 at +1. `wic_en_i`=0 → req_n high. Ack_n high → IDLE.
- Load mask 0x4 (IRQ0), enter deep sleep, pulse `int_i`[2] for 1 cycle → `wic_pend_o`=0x4 at +1 and `wakeup_o`=1 at +2. Pulse `int_i`[3] → no pend.
- In SLEEP, assert `wic_clear_i` together with a new `int_i`[1] (NMI) on mask 0x2 → pend=0x2 and `wakeup_o` remains asserted.
- ARMED with ack_n driven high → state REQ, `mask_vld`=0. Deep sleep with `mask_vld`=0 is not entered.
- SLEEP with ack_n forced high → `wakeup_o`=1 with pend=0. Drop `sleeping_i` → REQ, req_n stays low.
- `hreset_n` asserted while in SLEEP with pend=0x1 → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/cm0_wic_pkg.sv
// Shared definitions for the WIC sequencer: one-hot FSM encoding and wake-up line indices.
package cm0_wic_pkg;

    localparam int WIC_RXEV = 0;
    localparam int WIC_NMI  = 1;
    localparam int WIC_IRQ0 = 2;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_REQ   = 5'b00010,
        ST_ARMED = 5'b00100,
        ST_SLEEP = 5'b01000,
        ST_DROP  = 5'b10000
    } wic_state_e;

endpackage

// File: rtl/cm0_wic_seq_if.sv
// NVIC / power-controller facing signal bundle of the WIC sequencer.
interface cm0_wic_seq_if #(
    parameter int WICLINES = 34
);
    logic                wic_en_i;
    logic                wic_ds_ack_n_i;
    logic                wic_load_i;
    logic                wic_clear_i;
    logic [WICLINES-1:0] wic_mask_i;
    logic                sleeping_i;
    logic                sleep_deep_i;
    logic [WICLINES-1:0] int_i;
    logic                wic_ds_req_n_o;
    logic [WICLINES-1:0] wic_mask_o;
    logic [WICLINES-1:0] wic_pend_o;
    logic                wakeup_o;
    logic                wic_active_o;

    modport master (
        output wic_en_i, wic_ds_ack_n_i, wic_load_i, wic_clear_i, wic_mask_i,
        output sleeping_i, sleep_deep_i, int_i,
        input  wic_ds_req_n_o, wic_mask_o, wic_pend_o, wakeup_o, wic_active_o
    );

    modport slave (
        input  wic_en_i, wic_ds_ack_n_i, wic_load_i, wic_clear_i, wic_mask_i,
        input  sleeping_i, sleep_deep_i, int_i,
        output wic_ds_req_n_o, wic_mask_o, wic_pend_o, wakeup_o, wic_active_o
    );

endinterface

// File: rtl/cm0_wic_pend.sv
// WIC mask and pending-event registers; a set always wins over a same-cycle clear.
module cm0_wic_pend #(
    parameter int WICLINES = 34
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clear,
    input  logic                vld_clr,
    input  logic                mask_clr,
    input  logic                set_en,
    input  logic [WICLINES-1:0] mask_in,
    input  logic [WICLINES-1:0] lines,
    output logic [WICLINES-1:0] mask,
    output logic [WICLINES-1:0] pend,
    output logic                mask_vld,
    output logic                pend_any
);

    logic [WICLINES-1:0] set;

    assign set      = set_en ? (lines & mask) : '0;
    assign pend_any = |pend;

    // NOTE: every register here uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask     <= '0;
            pend     <= '0;
            mask_vld <= 1'b0;
        end else begin
            if (clear || mask_clr) begin
                mask <= '0;
            end else if (load) begin
                mask <= mask_in;
            end

            if (clear || mask_clr || vld_clr) begin
                mask_vld <= 1'b0;
            end else if (load) begin
                mask_vld <= 1'b1;
            end

            pend <= (clear ? '0 : pend) | set;
        end
    end

endmodule

// File: rtl/cm0_wic_seq.sv
// WIC deep-sleep handshake FSM with event latching and wake-up request generation.
module cm0_wic_seq #(
    parameter int WICLINES = 34
) (
    input  logic          sclk,
    input  logic          hreset_n,
    cm0_wic_seq_if.slave  bus
);
    import cm0_wic_pkg::*;

    wic_state_e state, state_nxt;
    logic       frc, frc_nxt;
    logic       req_n_q, active_q, wake_q;
    logic       owns_mask, mask_vld, pend_any;

    assign owns_mask = (state == ST_ARMED) || (state == ST_SLEEP);

    cm0_wic_pend #(.WICLINES(WICLINES)) u_pend (
        .clk      (sclk),
        .rst_n    (hreset_n),
        .load     (bus.wic_load_i & owns_mask),
        .clear    (bus.wic_clear_i & owns_mask),
        .vld_clr  ((state == ST_ARMED) && (state_nxt == ST_REQ)),
        .mask_clr ((state != ST_IDLE) && (state_nxt == ST_IDLE)),
        .set_en   (state == ST_SLEEP),
        .mask_in  (bus.wic_mask_i),
        .lines    (bus.int_i),
        .mask     (bus.wic_mask_o),
        .pend     (bus.wic_pend_o),
        .mask_vld (mask_vld),
        .pend_any (pend_any)
    );

    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_nxt = state;
        frc_nxt   = 1'b0;
        case (state)
            ST_IDLE:  if (bus.wic_en_i) state_nxt = ST_REQ;
            ST_REQ: begin
                if (!bus.wic_ds_ack_n_i)  state_nxt = ST_ARMED;
                else if (!bus.wic_en_i)   state_nxt = ST_DROP;
            end
            ST_ARMED: begin
                if (!bus.wic_en_i)          state_nxt = ST_DROP;
                else if (bus.wic_ds_ack_n_i) state_nxt = ST_REQ;
                else if (bus.sleeping_i && bus.sleep_deep_i && mask_vld) state_nxt = ST_SLEEP;
            end
            ST_SLEEP: begin
                // A lost acknowledge during sleep forces a fresh handshake on wake.
                if (!bus.sleeping_i) state_nxt = (frc || bus.wic_ds_ack_n_i) ? ST_REQ : ST_ARMED;
                else                 frc_nxt   = frc || bus.wic_ds_ack_n_i;
            end
            ST_DROP:  if (bus.wic_ds_ack_n_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state    <= ST_IDLE;
            frc      <= 1'b0;
            req_n_q  <= 1'b1;
            active_q <= 1'b0;
            wake_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            frc      <= frc_nxt;
            req_n_q  <= !(state_nxt inside {ST_REQ, ST_ARMED, ST_SLEEP});
            active_q <= (state_nxt == ST_ARMED) || (state_nxt == ST_SLEEP);
            wake_q   <= (state_nxt == ST_SLEEP) && (pend_any || frc);
        end
    end

    assign bus.wic_ds_req_n_o = req_n_q;
    assign bus.wic_active_o   = active_q;
    assign bus.wakeup_o       = wake_q;

endmodule
